// File: rtl/pll_lock_reset_seq_pkg.sv
// pll_rst_pkg: shared state encoding, default parameters and counter sizing for pll_lock_reset_seq.
// Revision 1.0
`default_nettype none

package pll_rst_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_HOLD      = 2'b10,
    ST_RUN       = 2'b11
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES   = 16;
  localparam int DEF_LOSS_W        = 8;

  // The shared counter only has to reach the larger of the two windows.
  function automatic int cnt_width(input int filter_cycles, input int hold_cycles);
    int largest;
    largest = (filter_cycles > hold_cycles) ? filter_cycles : hold_cycles;
    return $clog2(largest + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_reset_seq_lock_sync.sv
// lock_sync: multi-flop synchronizer for the asynchronous PLL lock, synchronously cleared.
// Revision 1.0
`default_nettype none

module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: filters PLL lock into a clean synchronous reset with hold-off and loss counting.
// Revision 1.0
`default_nettype none

module pll_lock_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int LOSS_W        = DEF_LOSS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock_i,
  input  logic              rst_req,
  output logic              rst_out,
  output logic              ready,
  output logic [1:0]        state_o,
  output logic [LOSS_W-1:0] lock_lost_cnt
);

  localparam int CNT_W = cnt_width(FILTER_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             lock_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             loss_inc;

  lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock_i),
    .q   (lock_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_inc  = 1'b0;
    case (state)
      ST_RESET: begin
        state_nxt = ST_WAIT_LOCK;
        cnt_nxt   = '0;
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_nxt = '0;
        end else if (cnt == FILT_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        // Losing lock during hold-off goes back to filtering and is not a counted loss.
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (rst_req) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
          loss_inc  = 1'b1;
        end else if (rst_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_RESET;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RESET;
      cnt           <= '0;
      rst_out       <= 1'b1;
      ready         <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rst_out <= (state_nxt != ST_RUN);
      ready   <= (state_nxt == ST_RUN);
      if (loss_inc && (lock_lost_cnt != {LOSS_W{1'b1}})) begin
        lock_lost_cnt <= lock_lost_cnt + 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: directed and randomized checks of pll_lock_reset_seq against a cycle model.
// Revision 1.0
`default_nettype none

module tb_pll_lock_reset_seq;

  localparam int SYNC = 2;
  localparam int FILT = 8;
  localparam int HOLD = 4;
  localparam int LW   = 8;

  localparam logic [1:0] P_RESET = 2'd0;
  localparam logic [1:0] P_WAIT  = 2'd1;
  localparam logic [1:0] P_HOLD  = 2'd2;
  localparam logic [1:0] P_RUN   = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lock_i = 1'b0;
  logic          rst_req = 1'b0;
  logic          rst_out;
  logic          ready;
  logic [1:0]    state_o;
  logic [LW-1:0] lock_lost_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: lock delay line, phase, lock streak, elapsed hold cycles, loss tally.
  logic       m_sync[SYNC];
  logic [1:0] m_phase = P_RESET;
  int         m_streak = 0;
  int         m_hold = 0;
  int         m_loss = 0;

  pll_lock_reset_seq #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .HOLD_CYCLES   (HOLD),
    .LOSS_W        (LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lock_i        (lock_i),
    .rst_req       (rst_req),
    .rst_out       (rst_out),
    .ready         (ready),
    .state_o       (state_o),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic ls;
    @(posedge clk);
    if (rst) begin
      m_phase = P_RESET; m_streak = 0; m_hold = 0; m_loss = 0;
      for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    end else begin
      ls = m_sync[SYNC-1];
      case (m_phase)
        P_RESET: begin m_phase = P_WAIT; m_streak = 0; end
        P_WAIT: begin
          if (!ls) m_streak = 0;
          else begin
            m_streak++;
            if (m_streak == FILT) begin m_phase = P_HOLD; m_hold = 0; end
          end
        end
        P_HOLD: begin
          if (!ls) begin m_phase = P_WAIT; m_streak = 0; end
          else if (rst_req) m_hold = 0;
          else begin
            m_hold++;
            if (m_hold == HOLD) m_phase = P_RUN;
          end
        end
        default: begin
          if (!ls) begin
            m_phase = P_WAIT; m_streak = 0;
            if (m_loss < (1 << LW) - 1) m_loss++;
          end else if (rst_req) begin
            m_phase = P_HOLD; m_hold = 0;
          end
        end
      endcase
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = lock_i;
    end
    #1;
  endtask

  task automatic goto_run();
    rst = 1'b0; rst_req = 1'b0; lock_i = 1'b1;
    for (int i = 0; i < 80 && m_phase != P_RUN; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; lock_i = 1'b0; rst_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (state_o !== P_RESET || rst_out !== 1'b1 || ready !== 1'b0 || lock_lost_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset: state=%b rst_out=%b ready=%b loss=%0d, required state=00 rst_out=1 ready=0 loss=0",
               state_o, rst_out, ready, lock_lost_cnt);
    end
  endtask

  task automatic test_lock_acquire();
    int         fall_edge;
    logic       bad;
    logic [1:0] seq[$];
    fall_edge = -1; bad = 1'b0;
    rst = 1'b0; lock_i = 1'b1; rst_req = 1'b0;
    seq.push_back(state_o);
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (state_o !== seq[$]) seq.push_back(state_o);
      if (fall_edge < 0 && rst_out === 1'b0) fall_edge = e;
      if (fall_edge < 0 && (rst_out !== 1'b1 || ready !== 1'b0)) bad = 1'b1;
      n_tests++;
      if (state_o !== m_phase || rst_out !== (m_phase != P_RUN) || ready !== (m_phase == P_RUN)) begin
        n_fail++;
        $display("FAIL acquire_edge%0d: state=%b rst_out=%b ready=%b, required state=%b", e, state_o, rst_out, ready, m_phase);
      end
    end
    n_tests++;
    if (fall_edge != 14) begin
      n_fail++;
      $display("FAIL acquire_latency: rst_out fell at edge %0d, required 14", fall_edge);
    end
    n_tests++;
    if (seq.size() != 4 || seq[0] !== P_RESET || seq[1] !== P_WAIT || seq[2] !== P_HOLD || seq[3] !== P_RUN) begin
      n_fail++;
      $display("FAIL acquire_sequence: %0d distinct states seen, required 00->01->10->11", seq.size());
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL acquire_outputs: rst_out/ready were 0/1 before the release edge, required 1/0");
    end
  endtask

  task automatic test_filter_restart();
    int hold_edge;
    hold_edge = -1;
    rst = 1'b1; lock_i = 1'b0; rst_req = 1'b0;
    tick(); tick();
    rst = 1'b0; lock_i = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 6) lock_i = 1'b0;
      if (e == 7) lock_i = 1'b1;
      if (hold_edge < 0 && state_o === P_HOLD) hold_edge = e;
      n_tests++;
      if (state_o !== m_phase) begin
        n_fail++;
        $display("FAIL filter_edge%0d: state=%b, required %b", e, state_o, m_phase);
      end
    end
    n_tests++;
    if (hold_edge != 17) begin
      n_fail++;
      $display("FAIL filter_restart: HOLD entered at edge %0d, required 17", hold_edge);
    end
  endtask

  task automatic test_sw_reset();
    int          highs;
    logic [LW-1:0] loss0;
    goto_run();
    loss0 = lock_lost_cnt;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    highs = 0;
    for (int i = 0; i < 20 && rst_out === 1'b1; i++) begin highs++; tick(); end
    n_tests++;
    if (highs != 4 || state_o !== P_RUN) begin
      n_fail++;
      $display("FAIL sw_reset_single: rst_out high %0d cycles then state=%b, required 4 then 11", highs, state_o);
    end
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    tick(); tick();
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    highs = 0;
    for (int i = 0; i < 20 && rst_out === 1'b1; i++) begin highs++; tick(); end
    n_tests++;
    if (highs != 4 || state_o !== P_RUN) begin
      n_fail++;
      $display("FAIL sw_reset_restart: rst_out high %0d cycles after second pulse, required 4", highs);
    end
    n_tests++;
    if (lock_lost_cnt !== loss0) begin
      n_fail++;
      $display("FAIL sw_reset_loss: loss=%0d, required %0d", lock_lost_cnt, loss0);
    end
  endtask

  task automatic test_simultaneous();
    logic [LW-1:0] loss0;
    goto_run();
    loss0 = lock_lost_cnt;
    lock_i = 1'b0;
    tick(); tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    n_tests++;
    if (state_o !== P_WAIT || rst_out !== 1'b1 || lock_lost_cnt !== loss0 + 1'b1) begin
      n_fail++;
      $display("FAIL loss_vs_req: state=%b rst_out=%b loss=%0d, required 01 1 %0d", state_o, rst_out, lock_lost_cnt, loss0 + 1);
    end
    lock_i = 1'b1;
    for (int i = 0; i < 40 && m_phase != P_HOLD; i++) tick();
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if (state_o !== P_RESET || lock_lost_cnt !== '0 || rst_out !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_hold: state=%b loss=%0d rst_out=%b, required 00 0 1", state_o, lock_lost_cnt, rst_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_loss();
    for (int n = 0; n < 300; n++) begin
      goto_run();
      lock_i = 1'b0;
      for (int e = 1; e <= 3; e++) begin
        tick();
        n_tests++;
        if (state_o !== m_phase || rst_out !== (m_phase != P_RUN) || lock_lost_cnt !== LW'(m_loss)) begin
          n_fail++;
          $display("FAIL lock_loss_%0d_edge%0d: state=%b rst_out=%b loss=%0d, required %b %b %0d",
                   n, e, state_o, rst_out, lock_lost_cnt, m_phase, (m_phase != P_RUN), m_loss);
        end
      end
    end
    n_tests++;
    if (lock_lost_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL loss_saturate: loss=%0d, required 255", lock_lost_cnt);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0; lock_i = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 6) lock_i = ~lock_i;
      if (!lock_i && $urandom_range(0, 99) < 30) lock_i = 1'b1;
      rst_req = ($urandom_range(0, 99) < 4);
      rst     = ($urandom_range(0, 999) < 3);
      tick();
      n_tests++;
      if (state_o !== m_phase || rst_out !== (m_phase != P_RUN) || ready !== (m_phase == P_RUN)
          || lock_lost_cnt !== LW'(m_loss)) begin
        n_fail++;
        $display("FAIL random_c%0d: state=%b rst_out=%b ready=%b loss=%0d, required state=%b loss=%0d",
                 c, state_o, rst_out, ready, lock_lost_cnt, m_phase, m_loss);
      end
    end
    rst = 1'b0; rst_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    test_reset();
    test_lock_acquire();
    test_filter_restart();
    test_sw_reset();
    test_simultaneous();
    test_lock_loss();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
